// File: rtl/bus_peripheral_responder.sv
// Memory-mapped peripheral responder: reloadable timer with IRQ, LED and 7-seg registers.
// Optional free-running SYSTICK counter is built only when PERIPH_SYSTICK_EN is defined.
module bus_peripheral_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [31:0]          MemBus_Address,
    input  logic [31:0]          MemBus_Write_Data,
    output logic [31:0]          Device_Read_Data,
    output logic                 dev_hit,
    output logic                 irq,
    output logic [LED_WIDTH-1:0] led,
    output logic [11:0]          digits
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DIGIT_W = 12;
    localparam int unsigned TCON_W  = 3;

    localparam logic [2:0] IDX_TH      = 3'd0;
    localparam logic [2:0] IDX_TL      = 3'd1;
    localparam logic [2:0] IDX_TCON    = 3'd2;
    localparam logic [2:0] IDX_LED     = 3'd3;
    localparam logic [2:0] IDX_DIGITS  = 3'd4;
    localparam logic [2:0] IDX_SYSTICK = 3'd5;

    logic [DATA_W-1:0]    th_q, th_d;
    logic [DATA_W-1:0]    tl_q, tl_d;
    logic [TCON_W-1:0]    tcon_q, tcon_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [DIGIT_W-1:0]   digits_q, digits_d;
    logic                 irq_q, irq_d;
    logic [DATA_W-1:0]    systick_rd;

    logic [2:0]        reg_idx;
    logic              wr_hit;
    logic              timer_ovf;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^MemBus_Address[1:0];

`ifdef PERIPH_SYSTICK_EN
    logic [DATA_W-1:0] systick_q, systick_d;

    always_comb begin
        systick_d = systick_q + DATA_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) systick_q <= '0;
        else       systick_q <= systick_d;
    end

    assign systick_rd = systick_q;
`else
    assign systick_rd = '0;
`endif

    // Address decode and zero-latency read mux
    always_comb begin
        dev_hit = (MemBus_Address[31:5] == BASE_ADDR[31:5]);
        reg_idx = MemBus_Address[4:2];
        wr_hit  = MemWrite & dev_hit;
        rd_mux  = '0;
        case (reg_idx)
            IDX_TH:      rd_mux = th_q;
            IDX_TL:      rd_mux = tl_q;
            IDX_TCON:    rd_mux = DATA_W'(tcon_q);
            IDX_LED:     rd_mux = DATA_W'(led_q);
            IDX_DIGITS:  rd_mux = DATA_W'(digits_q);
            IDX_SYSTICK: rd_mux = systick_rd;
            default:     rd_mux = '0;
        endcase
        Device_Read_Data = (MemRead & dev_hit) ? rd_mux : '0;
    end

    // Next-state: a CPU write to TL suppresses the timer; reload uses pre-write TH
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digits_d  = digits_q;
        timer_ovf = 1'b0;

        if (tcon_q[0] && !(wr_hit && reg_idx == IDX_TL)) begin
            if (tl_q == '1) begin
                tl_d      = th_q;
                timer_ovf = 1'b1;
            end else begin
                tl_d = tl_q + DATA_W'(1);
            end
        end

        if (wr_hit) begin
            case (reg_idx)
                IDX_TH:     th_d     = MemBus_Write_Data;
                IDX_TL:     tl_d     = MemBus_Write_Data;
                IDX_TCON:   tcon_d   = MemBus_Write_Data[TCON_W-1:0];
                IDX_LED:    led_d    = MemBus_Write_Data[LED_WIDTH-1:0];
                IDX_DIGITS: digits_d = MemBus_Write_Data[DIGIT_W-1:0];
                default:    ;
            endcase
        end

        // Hardware set of IF wins over a same-cycle software clear
        if (timer_ovf && tcon_q[1]) tcon_d[2] = 1'b1;

        irq_d = tcon_d[1] & tcon_d[2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q     <= '0;
            tl_q     <= '0;
            tcon_q   <= '0;
            led_q    <= '0;
            digits_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            th_q     <= th_d;
            tl_q     <= tl_d;
            tcon_q   <= tcon_d;
            led_q    <= led_d;
            digits_q <= digits_d;
            irq_q    <= irq_d;
        end
    end

    assign irq    = irq_q;
    assign led    = led_q;
    assign digits = digits_q;

endmodule

// File: tb/tb_bus_peripheral_responder.sv
// Randomized and directed bench for bus_peripheral_responder against a register-level reference model.
module tb_bus_peripheral_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] MemBus_Address, MemBus_Write_Data;
    logic [31:0] Device_Read_Data;
    logic        dev_hit, irq;
    logic [7:0]  led;
    logic [11:0] digits;

    int total_cnt = 0;
    int pass_cnt  = 0;

    bus_peripheral_responder #(.BASE_ADDR(32'h4000_0000), .LED_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemBus_Address(MemBus_Address), .MemBus_Write_Data(MemBus_Write_Data),
        .Device_Read_Data(Device_Read_Data), .dev_hit(dev_hit), .irq(irq),
        .led(led), .digits(digits)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_th, m_tl, m_tick;
    logic        m_en, m_ie, m_if;
    logic [7:0]  m_led;
    logic [11:0] m_dig;

    function automatic logic m_hit(input logic [31:0] a);
        return a[31:5] == 27'h200_0000;
    endfunction

    function automatic logic [31:0] exp_read(input logic r, input logic [31:0] a);
        if (!r || !m_hit(a)) return 32'h0;
        case (a[4:2])
            3'd0: return m_th;
            3'd1: return m_tl;
            3'd2: return {29'h0, m_if, m_ie, m_en};
            3'd3: return {24'h0, m_led};
            3'd4: return {20'h0, m_dig};
`ifdef PERIPH_SYSTICK_EN
            3'd5: return m_tick;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_tick = 0; m_en = 0; m_ie = 0; m_if = 0; m_led = 0; m_dig = 0;
    endtask

    // One clock edge of the model: timer first from old state, then CPU write, then IF set
    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] wd);
        logic we, tl_wr, ovf, old_ie;
        we     = w && m_hit(a);
        tl_wr  = we && a[4:2] == 3'd1;
        old_ie = m_ie;
        ovf    = 1'b0;
        if (m_en && !tl_wr) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                m_tl = m_th;
                ovf  = 1'b1;
            end else begin
                m_tl = m_tl + 1;
            end
        end
        if (we) begin
            case (a[4:2])
                3'd0: m_th = wd;
                3'd1: m_tl = wd;
                3'd2: begin m_en = wd[0]; m_ie = wd[1]; m_if = wd[2]; end
                3'd3: m_led = wd[7:0];
                3'd4: m_dig = wd[11:0];
                default: ;
            endcase
        end
        if (ovf && old_ie) m_if = 1'b1;
        m_tick = m_tick + 1;
    endtask

    // One bus cycle: drive, sample combinational outputs mid-cycle, clock, advance model
    task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic hit);
        MemRead = r; MemWrite = w; MemBus_Address = a; MemBus_Write_Data = wd;
        #4;
        rdata = Device_Read_Data;
        hit   = dev_hit;
        @(posedge clk);
        model_step(w, a, wd);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] d; logic h;
        bus(1'b0, 1'b1, a, wd, d, h);
    endtask

    task automatic idle(input int n);
        logic [31:0] d; logic h;
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'h0, 32'h0, d, h);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic h;
        wr(32'h4000_0004, 32'h0000_1234);
        wr(32'h4000_0000, 32'h0000_0055);
        wr(32'h4000_000C, 32'h0000_00FF);
        wr(32'h4000_0010, 32'h0000_0ABC);
        wr(32'h4000_0008, 32'h0000_0007);
        MemRead = 1'b1; MemBus_Address = 32'h4000_0004;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total_cnt++;
        if (Device_Read_Data !== 32'h0) $display("FAIL reset_tl: got %h exp 0", Device_Read_Data);
        else pass_cnt++;
        MemBus_Address = 32'h4000_0000;
        #1;
        total_cnt++;
        if (Device_Read_Data !== 32'h0) $display("FAIL reset_th: got %h exp 0", Device_Read_Data);
        else pass_cnt++;
        MemBus_Address = 32'h4000_0008;
        #1;
        total_cnt++;
        if (Device_Read_Data !== 32'h0) $display("FAIL reset_tcon: got %h exp 0", Device_Read_Data);
        else pass_cnt++;
        total_cnt++;
        if (led !== 8'h0 || digits !== 12'h0 || irq !== 1'b0)
            $display("FAIL reset_outputs: got led=%h digits=%h irq=%b exp 0", led, digits, irq);
        else pass_cnt++;
        MemRead = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus(1'b1, 1'b0, 32'h4000_0014, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_systick: got %h exp 0", d);
        else pass_cnt++;
    endtask

    task automatic test_register_rw();
        logic [31:0] d; logic h;
        wr(32'h4000_000C, 32'h0000_00A5);
        wr(32'h4000_0010, 32'h0000_03FE);
        bus(1'b1, 1'b0, 32'h4000_000C, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'h0000_00A5 || h !== 1'b1) $display("FAIL led_read: got %h hit=%b exp 000000a5", d, h);
        else pass_cnt++;
        total_cnt++;
        if (led !== 8'hA5) $display("FAIL led_port: got %h exp a5", led);
        else pass_cnt++;
        bus(1'b1, 1'b0, 32'h4000_0011, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'h0000_03FE) $display("FAIL digits_read: got %h exp 000003fe", d);
        else pass_cnt++;
        total_cnt++;
        if (digits !== 12'h3FE) $display("FAIL digits_port: got %h exp 3fe", digits);
        else pass_cnt++;
        wr(32'h4000_0020, 32'h0000_0011);
        bus(1'b1, 1'b0, 32'h4000_0020, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'h0 || h !== 1'b0) $display("FAIL out_of_window: got %h hit=%b exp 0 hit=0", d, h);
        else pass_cnt++;
        total_cnt++;
        if (led !== 8'hA5) $display("FAIL outside_write_ignored: got %h exp a5", led);
        else pass_cnt++;
        wr(32'h4000_001C, 32'hFFFF_FFFF);
        bus(1'b1, 1'b0, 32'h4000_001C, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'h0 || h !== 1'b1) $display("FAIL reserved_read: got %h hit=%b exp 0 hit=1", d, h);
        else pass_cnt++;
        bus(1'b1, 1'b1, 32'h4000_000C, 32'h0000_003C, d, h);
        total_cnt++;
        if (d !== 32'h0000_00A5 || led !== 8'h3C) $display("FAIL read_write_same: got %h led=%h exp a5 led=3c", d, led);
        else pass_cnt++;
    endtask

    task automatic test_timer_reload();
        logic [31:0] d; logic h;
        wr(32'h4000_0008, 32'h0);
        wr(32'h4000_0000, 32'hFFFF_FFFC);
        wr(32'h4000_0004, 32'hFFFF_FFFD);
        wr(32'h4000_0008, 32'h0000_0003);
        idle(3);
        bus(1'b1, 1'b0, 32'h4000_0004, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'hFFFF_FFFC) $display("FAIL reload_tl: got %h exp fffffffc", d);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b1 || m_if !== 1'b1) $display("FAIL reload_irq: got %b exp 1", irq);
        else pass_cnt++;
        wr(32'h4000_0008, 32'h0000_0003);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_clear: got %b exp 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_overflow_vs_clear();
        logic [31:0] d; logic h;
        wr(32'h4000_0008, 32'h0);
        wr(32'h4000_0000, 32'h0000_0010);
        wr(32'h4000_0004, 32'hFFFF_FFFE);
        wr(32'h4000_0008, 32'h0000_0003);
        idle(1);
        wr(32'h4000_0008, 32'h0000_0003);
        bus(1'b1, 1'b0, 32'h4000_0008, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'h0000_0007 || irq !== 1'b1) $display("FAIL hw_set_beats_clear: got tcon=%h irq=%b exp 7 irq=1", d, irq);
        else pass_cnt++;
        wr(32'h4000_0008, 32'h0000_0003);
        wr(32'h4000_0004, 32'hFFFF_FFFF);
        wr(32'h4000_0004, 32'h0000_0005);
        bus(1'b1, 1'b0, 32'h4000_0004, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'h0000_0005 || irq !== 1'b0) $display("FAIL tl_write_beats_reload: got tl=%h irq=%b exp 5 irq=0", d, irq);
        else pass_cnt++;
    endtask

    task automatic test_disabled_timer();
        logic [31:0] d; logic h;
        wr(32'h4000_0008, 32'h0);
        wr(32'h4000_0004, 32'h0000_0007);
        idle(10);
        bus(1'b1, 1'b0, 32'h4000_0004, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'h0000_0007 || irq !== 1'b0) $display("FAIL disabled_hold: got tl=%h irq=%b exp 7 irq=0", d, irq);
        else pass_cnt++;
        bus(1'b1, 1'b0, 32'h4000_0008, 32'h0, d, h);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL disabled_tcon: got %h exp 0", d);
        else pass_cnt++;
    endtask

    task automatic test_systick();
        logic [31:0] d1, d2, d3, e; logic h;
        bus(1'b1, 1'b0, 32'h4000_0014, 32'h0, d1, h);
        idle(9);
        bus(1'b1, 1'b0, 32'h4000_0014, 32'h0, d2, h);
`ifdef PERIPH_SYSTICK_EN
        total_cnt++;
        if (d2 - d1 !== 32'd10 || d1 === 32'h0) $display("FAIL systick_delta: got %h->%h exp delta 10", d1, d2);
        else pass_cnt++;
`else
        total_cnt++;
        if (d1 !== 32'h0 || d2 !== 32'h0) $display("FAIL systick_absent: got %h %h exp 0", d1, d2);
        else pass_cnt++;
`endif
        wr(32'h4000_0014, 32'h0);
        e = exp_read(1'b1, 32'h4000_0014);
        bus(1'b1, 1'b0, 32'h4000_0014, 32'h0, d3, h);
        total_cnt++;
        if (d3 !== e) $display("FAIL systick_write_ignored: got %h exp %h", d3, e);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a, wd, d, e; logic r, w, h;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1:       a = 32'h4000_0020 + 32'($urandom_range(0, 31));
                default: a = 32'h4000_0000 + 32'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 3))
                0:       wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       wd = 32'($urandom_range(0, 7));
                default: wd = $urandom;
            endcase
            r = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 2) == 0);
            e = exp_read(r, a);
            bus(r, w, a, wd, d, h);
            total_cnt++;
            if (d !== e || h !== m_hit(a))
                $display("FAIL random_read[%0d]: addr=%h got %h hit=%b exp %h hit=%b", i, a, d, h, e, m_hit(a));
            else pass_cnt++;
            total_cnt++;
            if (led !== m_led || digits !== m_dig || irq !== (m_ie & m_if))
                $display("FAIL random_ports[%0d]: got led=%h dig=%h irq=%b exp %h %h %b",
                         i, led, digits, irq, m_led, m_dig, m_ie & m_if);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; MemBus_Address = 32'h0; MemBus_Write_Data = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_register_rw();
        test_timer_reload();
        test_overflow_vs_clear();
        test_disabled_timer();
        test_systick();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
